// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver: synchronises the RX pin, validates the start and stop bits, and presents
// each byte on a valid/ready handshake with a one-entry holding register, plus error pulses.
module uart_rx_stream #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       m_aresetn,
    input  logic       uart_rxd,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    // state     | meaning
    // IDLE      | line idle, waiting for rxd_s to fall
    // START     | half-bit wait, then confirm the start bit is still low
    // DATA      | sample 8 data bits at mid-bit, LSB first
    // STOP      | sample the stop bit; deliver the byte or flag a framing error
    // WAIT_HIGH | after a framing error, wait for the line to return high
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state;
    logic             rxd_meta;
    logic             rxd_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    always_ff @(posedge clk or negedge m_aresetn) begin
        if (!m_aresetn) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_s    <= rxd_meta;
        end
    end

    always_ff @(posedge clk or negedge m_aresetn) begin
        if (!m_aresetn) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            rx_valid     <= 1'b0;
            rx_data      <= 8'h00;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rxd_s) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == HALF_TC) begin
                        cnt <= '0;
                        if (!rxd_s) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_TC) begin
                        cnt     <= '0;
                        shift   <= {rxd_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == BIT_TC) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            state <= S_IDLE;
                            // An accept on this same edge frees the register for the new byte.
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shift;
                                rx_valid <= 1'b1;
                            end else begin
                                rx_overrun <= 1'b1;
                            end
                        end else begin
                            state        <= S_WAIT_HIGH;
                            rx_frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    cnt <= '0;
                    if (rxd_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_stream.sv
// Scoreboard bench for uart_rx_stream at 16 clocks per bit: stimulus pushes expected bytes,
// a negedge monitor pops and compares on every accepted handshake and counts error pulses.
module tb_uart_rx_stream;

    localparam int CPB = 16;

    logic       clk;
    logic       m_aresetn;
    logic       uart_rxd;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overrun;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    int         obs_ferr = 0;
    int         obs_ovr  = 0;
    int         exp_ferr = 0;
    int         exp_ovr  = 0;

    // 0: ready tied high, 1: ready from rdy_force, 2: ready one cycle after valid rises
    int         rdy_mode  = 0;
    logic       rdy_force = 1'b0;
    logic       vprev     = 1'b0;

    uart_rx_stream #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk          (clk),
        .m_aresetn    (m_aresetn),
        .uart_rxd     (uart_rxd),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) vprev <= rx_valid;

    assign rx_ready = (rdy_mode == 0) ? 1'b1 :
                      (rdy_mode == 1) ? rdy_force : (rx_valid && vprev);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every accepted byte against the scoreboard head.
    always @(negedge clk) begin
        if (m_aresetn) begin
            if (rx_frame_err) obs_ferr++;
            if (rx_overrun) obs_ovr++;
            if (rx_valid && rx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL accept: unexpected byte %0h, no byte expected", rx_data);
                end else begin
                    automatic logic [7:0] e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        errors++;
                        $display("FAIL accept: got %0h expected %0h", rx_data, e);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = stop_val;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic chk_pulses(input string name);
        chk({name, "_ferr"}, obs_ferr, exp_ferr);
        chk({name, "_ovr"}, obs_ovr, exp_ovr);
    endtask

    initial begin
        m_aresetn = 1'b0;
        uart_rxd  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_ferr", rx_frame_err, 0);
        chk("rst_ovr", rx_overrun, 0);
        m_aresetn = 1'b1;
        idle(20);

        // Single frame, ready tied high
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        idle(20);
        wait_drain("a5_drain");
        chk_pulses("a5");

        // 5-clock low glitch is rejected, then a real frame
        uart_rxd = 1'b0;
        repeat (5) @(negedge clk);
        idle(40);
        chk("glitch_valid", rx_valid, 0);
        chk_pulses("glitch");
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        idle(20);
        wait_drain("3c_drain");

        // Framing error: stop held low for two bit times, then a good frame
        send_frame(8'h81, 1'b0);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        idle(2 * CPB);
        exp_ferr++;
        chk_pulses("ferr");
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        idle(20);
        wait_drain("55_drain");
        chk_pulses("ferr_after");

        // Overrun: ready held low across two back-to-back frames
        rdy_mode  = 1;
        rdy_force = 1'b0;
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        idle(10);
        exp_ovr++;
        chk_pulses("ovr");
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_data", rx_data, 8'h12);
        rdy_force = 1'b1;
        wait_drain("12_drain");
        repeat (3) @(negedge clk);
        chk("ovr_valid_after", rx_valid, 0);
        rdy_force = 1'b0;

        // Back-to-back frames, consumer answers one cycle late
        rdy_mode = 2;
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'hFF);
        send_frame(8'h02, 1'b1);
        send_frame(8'h0A, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(20);
        wait_drain("b2b_drain");
        chk_pulses("b2b");

        // Reset during data bit 4 of 0xC3, then 0x5A
        rdy_mode = 0;
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = (i < 2) ? 1'b1 : 1'b0;
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        m_aresetn = 1'b0;
        #1;
        chk("midrst_valid", rx_valid, 0);
        chk("midrst_data", rx_data, 8'h00);
        chk("midrst_ferr", rx_frame_err, 0);
        chk("midrst_ovr", rx_overrun, 0);
        uart_rxd = 1'b1;
        repeat (4) @(negedge clk);
        m_aresetn = 1'b1;
        idle(20);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        idle(20);
        wait_drain("5a_drain");
        chk_pulses("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_stream.md
Name: uart_rx_stream

Overview:
- Serial-to-byte UART receiver (8N1) directly upstream of the UART probe command FSM.
- Samples the asynchronous RX pin and validates the start and stop bits.
- Presents each received byte on an rx_valid/rx_data/rx_ready handshake whose producer holds data until accepted.
- A one-entry output holding register, plus framing-error and overrun pulses, give the host-side link basic diagnostics.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range 8..65535.
- CNT_W, 16, width of the bit-timing counter; must hold CLKS_PER_BIT-1.

Ports:
- clk  in  1  system clock.
- m_aresetn  in  1  asynchronous active-low reset.
- uart_rxd  in  1  raw serial input, asynchronous to clk, idle high.
- rx_valid  out  1  rx_data holds an unaccepted byte.
- rx_data  out  8  received byte, LSB first on the wire.
- rx_ready  in  1  consumer accepts the byte in a cycle where rx_valid && rx_ready.
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- rx_overrun  out  1  one-cycle pulse: new byte completed while the holding register was full; the new byte is dropped.

Behaviour:
- Reset (async assert, sync-to-clk deassert at the consumer's discretion):
  - rx_valid=0, rx_data=8'h00, rx_frame_err=0, rx_overrun=0.
  - Synchroniser flops=1, FSM=IDLE, counter=0, bit index=0.
- Synchroniser: uart_rxd passes through 2 flops to give rxd_s. All decisions use rxd_s only.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rxd_s==0 -> START, counter cleared.
  - START: counter counts 0..CLKS_PER_BIT/2-1 (integer division). At the terminal count:
    - rxd_s==0 -> DATA, counter=0, bit index=0.
    - rxd_s==1 -> IDLE (glitch rejected, no pulse).
  - DATA: counter counts 0..CLKS_PER_BIT-1. At the terminal count:
    - Shift rxd_s in at bit 7, shifting right, so the first wire bit lands in bit 0.
    - Bit index +1; after the 8th sample -> STOP.
  - STOP: counter counts 0..CLKS_PER_BIT-1. At the terminal count, sample rxd_s:
    - 1 -> deliver the byte, then -> IDLE on the same edge, so back-to-back frames resynchronise on the next falling edge.
    - 0 -> rx_frame_err=1 for one cycle, byte discarded, -> WAIT_HIGH.
  - WAIT_HIGH: stay until rxd_s==1, then -> IDLE. This prevents re-framing inside a break or stuck-low line.
- Delivery, evaluated in the stop-sample cycle:
  - If rx_valid==0, or rx_valid && rx_ready in the same cycle: rx_data <= shift register, rx_valid <= 1 next cycle.
  - Otherwise: rx_overrun=1 for one cycle; rx_data and rx_valid unchanged (oldest byte kept).
- Handshake:
  - rx_valid and rx_data stay stable until the accepting cycle (rx_valid && rx_ready); rx_valid clears the following cycle unless a new byte loads on that edge.
  - rx_ready may be driven combinationally from rx_valid by the consumer. rx_valid is registered, so no combinational path from rx_ready to any output exists.
  - rx_ready while rx_valid==0 has no effect.
  - The block must tolerate a consumer asserting rx_ready one cycle after rx_valid rises.
- Latency: rx_valid rises 1 clk after the stop-bit sample, about 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clks after the falling start edge on uart_rxd.
- Simultaneous events:
  - Accept and new delivery on the same edge: the new byte loads and rx_valid stays 1.
  - Frame error never produces an overrun pulse.
  - rx_frame_err and rx_overrun never assert in the same cycle.
- Reset mid-frame: the partial byte is discarded and the FSM returns to IDLE. If the line is low at deassert, the receiver treats it as a start edge and relies on start/stop validation to reject it.
- Counter: CNT_W bits, no wrap within legal CLKS_PER_BIT; cleared on every state change.

Test Plan:
- All scenarios use CLKS_PER_BIT=16.
- Frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop), rx_ready tied 1 -> exactly one rx_valid cycle with rx_data=0xA5; no error pulses.
- Low glitch of 5 clks on uart_rxd from idle -> FSM returns to IDLE; no rx_valid, no rx_frame_err. A following frame 0x3C is received as 0x3C.
- Frame 0x81 with the stop bit driven 0 for 2 bit times, then line high, then frame 0x55 -> one rx_frame_err pulse, no rx_valid for 0x81, then rx_data=0x55 delivered.
- Back-to-back frames 0x12, 0x34 with rx_ready held 0 -> rx_valid=1 with rx_data=0x12 throughout, one rx_overrun pulse at the 0x34 stop sample. Raising rx_ready then yields one accept of 0x12 and rx_valid=0 afterwards.
- Back-to-back frames 0x02, 0x0A, 0xFF with the consumer asserting rx_ready one cycle after rx_valid -> three accepts in order 0x02, 0x0A, 0xFF; no overrun.
- Assert m_aresetn=0 during DATA bit 4 of frame 0xC3, release, then send 0x5A -> outputs at reset values during reset; the next delivered byte is 0x5A only.
